// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, addresses the program ROM and registers the returned
// word into the IF/ID pipeline register, with stall, redirect/flush and a debug counter.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
  parameter int unsigned COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall_i,
  input  logic               redirect_i,
  input  logic [31:0]        redirect_pc_i,
  output logic [31:0]        Rom_addr,
  input  logic [31:0]        Rom_data,
  output logic               if_id_valid,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_pc_plus4,
  output logic               misalign_o,
  output logic [COUNT_W-1:0] fetch_count
);

  localparam logic [31:0]        PC_RST  = {RESET_PC[31:2], 2'b00};
  localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

  logic [31:0]        pc_q, pc_d;
  logic               valid_q, valid_d;
  logic [31:0]        instr_q, instr_d;
  logic [31:0]        id_pc_q, id_pc_d;
  logic [31:0]        id_pc4_q, id_pc4_d;
  logic               misalign_q, misalign_d;
  logic [COUNT_W-1:0] count_q, count_d;

  // Redirect outranks stall so a taken branch is never lost behind a hazard.
  always_comb begin
    pc_d       = pc_q;
    valid_d    = valid_q;
    instr_d    = instr_q;
    id_pc_d    = id_pc_q;
    id_pc4_d   = id_pc4_q;
    misalign_d = misalign_q;
    count_d    = count_q;
    if (redirect_i) begin
      pc_d       = {redirect_pc_i[31:2], 2'b00};
      valid_d    = 1'b0;
      instr_d    = NOP_INSTR;
      id_pc_d    = '0;
      id_pc4_d   = '0;
      misalign_d = misalign_q | (|redirect_pc_i[1:0]);
    end else if (!stall_i) begin
      pc_d     = pc_q + 32'd4;
      valid_d  = 1'b1;
      instr_d  = Rom_data;
      id_pc_d  = pc_q;
      id_pc4_d = pc_q + 32'd4;
      if (count_q != '1) begin
        count_d = count_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= PC_RST;
      valid_q    <= 1'b0;
      instr_q    <= NOP_INSTR;
      id_pc_q    <= '0;
      id_pc4_q   <= '0;
      misalign_q <= 1'b0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      instr_q    <= instr_d;
      id_pc_q    <= id_pc_d;
      id_pc4_q   <= id_pc4_d;
      misalign_q <= misalign_d;
      count_q    <= count_d;
    end
  end

  assign Rom_addr       = pc_q;
  assign if_id_valid    = valid_q;
  assign if_id_instr    = instr_q;
  assign if_id_pc       = id_pc_q;
  assign if_id_pc_plus4 = id_pc4_q;
  assign misalign_o     = misalign_q;
  assign fetch_count    = count_q;

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Fetch stage of the single-issue RV32 core on DE0-CV. It owns the program counter and drives the combinational program ROM address. It captures the returned instruction into the IF/ID pipeline register for decode. It handles decode/execute stalls, branch/jump redirects and pipeline flush, and keeps a saturating fetched-instruction counter for debug LEDs.

Parameters:
RESET_PC, 32'h00000000, PC value loaded on reset.
NOP_INSTR, 32'h00000013, bubble instruction (addi x0 x0 0) injected on flush and reset.
COUNT_W, 16, width of the fetched-instruction counter.

Ports:
clk  input  1  core clock; all state updates on the rising edge.
rst_n  input  1  asynchronous active-low reset.
stall_i  input  1  hold PC and IF/ID (hazard from decode/execute).
redirect_i  input  1  taken branch/jump from execute; loads redirect_pc_i, flushes IF/ID.
redirect_pc_i  input  32  redirect target byte address.
Rom_addr  output  32  instruction address to program ROM; equals PC register.
Rom_data  input  32  instruction word from ROM, valid in the same cycle as Rom_addr.
if_id_valid  output  1  IF/ID holds a real instruction.
if_id_instr  output  32  fetched instruction.
if_id_pc  output  32  address of if_id_instr.
if_id_pc_plus4  output  32  if_id_pc + 4, link value for jal/jalr.
misalign_o  output  1  sticky flag: a redirect target had non-zero bits [1:0].
fetch_count  output  COUNT_W  number of instructions accepted into IF/ID, saturating.

Behaviour:
- Reset (async, rst_n=0), applied immediately even mid-operation:
  - pc=RESET_PC, if_id_valid=0, if_id_instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0.
  - misalign_o=0, fetch_count=0.
- Rom_addr is driven directly from the pc register. There is no combinational path from any input to Rom_addr.
- Per rising edge, priority order (highest first):
  1. redirect_i=1, regardless of stall_i:
     - pc <= {redirect_pc_i[31:2],2'b00}.
     - IF/ID flushed: valid=0, instr=NOP_INSTR, if_id_pc=0, if_id_pc_plus4=0.
     - misalign_o <= misalign_o | (|redirect_pc_i[1:0]).
     - fetch_count unchanged.
  2. stall_i=1, no redirect: pc and all IF/ID fields hold. fetch_count holds.
  3. Otherwise (advance):
     - if_id_instr <= Rom_data, if_id_pc <= pc, if_id_pc_plus4 <= pc+4, if_id_valid <= 1.
     - pc <= pc+4.
     - fetch_count <= fetch_count+1, saturating at all-ones.
- Latency: the instruction at address A appears on if_id_instr one edge after pc==A. After a redirect there is exactly one bubble cycle (valid=0) before the target instruction appears.
- PC arithmetic is modulo 2^32: 32'hFFFFFFFC + 4 = 32'h00000000. No flag is raised on wrap.
- misalign_o clears only on reset. The PC is never misaligned; bits [1:0] of pc are always 0.
- The first edge after reset deassertion is an ordinary advance. No extra warm-up cycle.
- The block performs no decoding of Rom_data; the data is passed through untouched.

Test Plan:
1. Reset release with the standard program image -> Rom_addr=0x0 before the first edge. After edge 1: if_id_instr=0x00500113, if_id_pc=0x0, if_id_pc_plus4=0x4, if_id_valid=1, Rom_addr=0x4, fetch_count=1.
2. Advance to pc=0x10, then hold stall_i=1 for 3 edges -> Rom_addr stays 0x10, if_id_instr stays 0x00312023 (from 0x0C), fetch_count stays 4. On release: if_id_instr=0x6E0561B7, Rom_addr=0x14.
3. Redirect with redirect_pc_i=0x34 -> next cycle Rom_addr=0x34, if_id_valid=0, if_id_instr=0x00000013. Following edge: if_id_instr=0x00010183, if_id_pc=0x34, if_id_pc_plus4=0x38.
4. stall_i=1 and redirect_i=1 together, target 0x5C -> redirect wins: Rom_addr=0x5C, IF/ID flushed. Next edge with stall_i=0: if_id_instr=0x00010183 (the instruction at 0x5C).
5. Redirect to 0x36 -> Rom_addr=0x34, misalign_o=1. Further aligned redirects leave misalign_o=1. Async reset pulse mid-cycle clears it at once and Rom_addr returns to 0x0 without waiting for a clock edge.
6. RESET_PC=0xFFFFFFFC, COUNT_W=4 -> after edge 1 Rom_addr=0x0 (wrap) and if_id_pc=0xFFFFFFFC. After 20 unstalled edges fetch_count=4'hF (saturated).
